rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. It sits in front of the shared datapath and uses a priority search from a rotating pointer so that no requester starves. It grants one requester at a time and holds the grant until the owner finishes, withdraws, or exceeds a hold-time limit. It also reports the granted index in 3-bit encoded form for the downstream mux select.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one grant may be held before forced release (legal range 2..256)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  request per requester; held high until served or withdrawn
done  input  1  owner/resource signals end of transaction; meaningful only in GRANT
gnt  output  8  one-hot grant, all-zero when idle
gnt_id  output  3  encoded index of current grant (0 when idle)
gnt_valid  output  1  high while a grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low, and applies at any time, including mid-grant. On reset: state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - If req != 0 at a rising edge, select the first set bit searching ptr, ptr+1, ..., wrapping from 7 to 0.
  - At that same edge: gnt=onehot(sel), gnt_id=sel, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to gnt visible is 1 cycle.
  - If req == 0, remain in IDLE with outputs at zero.
- GRANT: the owner is gnt_id. Each edge evaluates in this priority order:
  1. done=1 → release.
  2. req[gnt_id]=0 → release (withdrawal).
  3. hold_cnt == MAX_HOLD-1 → release, and timeout=1 for the following cycle.
  4. Otherwise hold_cnt += 1 and the grant is held.
- Release (at the edge):
  - gnt=0, gnt_valid=0, gnt_id=0.
  - ptr = (owner+1) mod 8.
  - state=IDLE.
  - There is always exactly one idle cycle between consecutive grants.
- timeout is high only in the IDLE cycle that follows a forced release, and low otherwise. If done and the hold limit coincide, done wins and timeout stays 0.
- Requests other than the owner's that change during GRANT have no effect until the next IDLE evaluation.
- done asserted in IDLE is ignored.
- ptr is 3 bits and wraps naturally (7+1 → 0).
- A grant therefore lasts between 1 and MAX_HOLD cycles.
- gnt is never multi-hot. gnt_valid == |gnt and gnt == onehot(gnt_id) whenever gnt_valid=1; the bench checks these as assertions every cycle.
- Fairness: with all 8 requests continuously high and done pulsed each grant, grants cycle 0,1,...,7,0.

Test Plan:
- Reset check: rst_n=0 asserted asynchronously mid-grant (gnt=8'h08) → outputs drop to 0 immediately, without waiting for a clock edge. After release with req=8'hFF, the first grant is gnt=8'h01, gnt_id=0.
- Rotation: req=8'hFF held, done pulsed on each grant's first cycle → gnt_id sequence 0,1,2,3,4,5,6,7,0, with gnt=0 for one cycle between each pair of grants.
- Wrap search: ptr=6 (after serving id 5), req=8'b0000_0110 → grant id 1 (gnt=8'h02); next grant with same req → id 2.
- Timeout: MAX_HOLD=4, req=8'h10 held, done=0 → gnt=8'h10 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle; next grant is id 4 again (only requester), timeout=0.
- Withdrawal and conflict: owner id 3 drops req[3] at cycle 2 → released at next edge, timeout=0. Separately, done=1 on the cycle hold_cnt==MAX_HOLD-1 → release with timeout=0.
- Idle behaviour: req=0 with random done pulses for 20 cycles → gnt=0, gnt_valid=0, timeout=0 throughout, and ptr unchanged (verified by next grant order from req=8'hFF).

Source files
------------

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a rotating priority pointer,
// a per-grant hold-time limit and an encoded grant index for the mux select.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] hold_q;
    logic [7:0]       gnt_q;
    logic [2:0]       id_q;
    logic             valid_q;
    logic             timeout_q;

    logic [2:0]       sel_d;
    logic             found_d;
    logic [2:0]       idx;

    // First set request at or after ptr_q, wrapping 7 -> 0.
    always_comb begin
        sel_d   = '0;
        found_d = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                sel_d   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (found_d) begin
                        gnt_q   <= 8'(1) << sel_d;
                        id_q    <= sel_d;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    timeout_q <= 1'b0;
                    if (done || !req[id_q] || (hold_q == CNT_W'(MAX_HOLD - 1))) begin
                        // done and withdrawal take precedence over the hold limit
                        timeout_q <= !done && req[id_q];
                        gnt_q     <= '0;
                        id_q      <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= id_q + 3'd1;
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int failed = 0;

    // Model state: owner index (-1 when idle), search start, cycles held so far.
    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    bit m_to = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(HOLD), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge();
        if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 1;
                end
            end
        end else if (done || !req[m_owner] || m_held == HOLD) begin
            m_to    = !done && req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] e_gnt;
        e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        cmp("gnt", gnt, e_gnt);
        cmp("gnt_id", {5'b0, gnt_id}, (m_owner < 0) ? 8'h00 : 8'(m_owner));
        cmp("gnt_valid", {7'b0, gnt_valid}, {7'b0, m_owner >= 0});
        cmp("timeout", {7'b0, timeout}, {7'b0, m_to});
        cmp("onehot0", {7'b0, $onehot0(gnt)}, 8'h01);
        cmp("valid_or", {7'b0, gnt_valid}, {7'b0, |gnt});
        if (gnt_valid) cmp("gnt_vs_id", gnt, 8'h01 << gnt_id);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        #2;
        model_reset();
        check_all();
        #10 rst_n = 1'b1;

        // Async reset mid-grant
        req = 8'h08;
        step();
        cmp("pre_reset_gnt", gnt, 8'h08);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("async_rst_gnt", gnt, 8'h00);
        #2 rst_n = 1'b1;
        req = 8'hFF;
        step();
        cmp("post_reset_first", gnt, 8'h01);

        // Rotation with done on each grant's first cycle
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            cmp("rotation_id", {5'b0, gnt_id}, 8'(i % 8));
            done = 1'b1;
            step();
            cmp("rotation_gap", gnt, 8'h00);
            done = 1'b0;
        end

        // Wrap search from ptr=6
        req = 8'h20;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req = 8'b0000_0110;
        step();
        cmp("wrap_first", gnt, 8'h02);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        cmp("wrap_second", gnt, 8'h04);
        done = 1'b1;
        step();
        done = 1'b0;

        // Hold limit forced release
        req = 8'h10;
        for (int i = 0; i < HOLD; i++) step();
        step();
        cmp("timeout_pulse", {7'b0, timeout}, 8'h01);
        step();
        cmp("timeout_regrant", gnt, 8'h10);
        done = 1'b1;
        step();
        done = 1'b0;

        // Withdrawal on cycle 2
        req = 8'h08;
        step();
        step();
        req = 8'h00;
        step();
        cmp("withdraw_rel", gnt, 8'h00);

        // done coincides with hold limit
        req = 8'h08;
        for (int i = 0; i < HOLD; i++) step();
        done = 1'b1;
        step();
        cmp("done_wins_to", {7'b0, timeout}, 8'h00);
        done = 1'b0;

        // Idle with stray done pulses
        req = 8'h00;
        for (int i = 0; i < 20; i++) begin
            done = 1'($urandom_range(0, 1));
            step();
        end
        done = 1'b0;
        req = 8'hFF;
        step();
        cmp("idle_ptr_kept", gnt, 8'h10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
